// File: rtl/mvm_pkg.sv
// ---------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for the matrix-vector datapath. It holds the dot8 pipeline
// latency, the default widths, and the row accumulator state encoding.
// It has no ports.
// ---------------------------------------------------------------------------
package mvm_pkg;

   // Number of pipeline stages in the dot8 unit. The stall hint must cover
   // every chunk that is already in flight, so it needs this many entries of
   // slack plus one.
   localparam int DOT8_LATENCY   = 5;

   localparam int DEF_IWIDTH     = 32;
   localparam int DEF_OWIDTH     = 32;
   localparam int DEF_CWIDTH     = 8;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_SLACK      = DOT8_LATENCY + 1;
   localparam int ROW_CNT_W      = 16;

   typedef enum logic {
      IDLE  = 1'b0,   // no row in progress
      ACCUM = 1'b1    // row open, more chunks expected
   } accum_state_t;

endpackage

// File: rtl/dot8_accum_if.sv
// ---------------------------------------------------------------------------
// dot8_accum_if
// Data path bundle of the row accumulator.
//   ivalid/idata : partial dot products from dot8 (no back-pressure possible)
//   odata/ovalid/oready : row totals towards the downstream consumer
// Modports:
//   master : the producer/consumer side (drives ivalid, idata, oready)
//   slave  : the accumulator side (drives odata, ovalid)
//
// Handshake: a row total transfers on every rising clk edge where ovalid and
// oready are both high. While ovalid is high and oready is low, odata holds
// its value. ovalid never depends on oready. ivalid has no ready. A chunk is
// taken on every edge where ivalid is high.
// ---------------------------------------------------------------------------
interface dot8_accum_if
   import mvm_pkg::*;
#(
   parameter int IWIDTH = DEF_IWIDTH,
   parameter int OWIDTH = DEF_OWIDTH
);
   logic              ivalid;
   logic [IWIDTH-1:0] idata;
   logic [OWIDTH-1:0] odata;
   logic              ovalid;
   logic              oready;

   modport master (
      output ivalid,
      output idata,
      output oready,
      input  odata,
      input  ovalid
   );

   modport slave (
      input  ivalid,
      input  idata,
      input  oready,
      output odata,
      output ovalid
   );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO. The head word is kept in a register.
//   clk, rst : clock, synchronous active-high reset
//   push     : write request. It is accepted if the FIFO is not full, or if a
//              pop happens in the same cycle.
//   wr_data  : word to write
//   pop      : read request. It is ignored while the FIFO is empty.
//   rd_data  : registered head word. It holds its value until the head changes.
//   count    : registered occupancy
//   full     : count == DEPTH
//   empty    : count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      rd_ptr_next;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_d;
   logic             push_ok;
   logic             pop_ok;

   // Each pointer has an extra wrap bit. Equal addresses with different wrap
   // bits mean the FIFO is full.
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign pop_ok  = pop && !empty;
   // If the FIFO is full, a push is still taken when a pop frees a slot in the
   // same cycle.
   assign push_ok = push && (!full || pop_ok);

   assign rd_ptr_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

   // Next head word. If it is the slot being written this cycle, take the
   // incoming word directly. This happens when the FIFO is, or is about to
   // be, empty.
   always_comb begin
      head_d = mem[rd_ptr_next[AW-1:0]];
      if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
         head_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_ptr_next;
         if (push_ok || pop_ok) begin
            head_q <= head_d;
         end
      end
   end

   assign rd_data = head_q;

endmodule

// File: rtl/dot8_accum.sv
// ---------------------------------------------------------------------------
// dot8_accum
// Adds cfg_chunks consecutive partial dot products into one row total and
// queues the total in an output FIFO. Also produces a stall hint for the
// issue controller.
//   clk, rst     : clock, synchronous active-high reset
//   cfg_chunks   : chunks per row. It is sampled on the first chunk of a row.
//                  A value of 0 is treated as 1.
//   bus          : slave side of dot8_accum_if
//                  (ivalid/idata in, odata/ovalid out, oready in)
//   almost_full  : free FIFO entries <= SLACK. Upstream stops issuing while
//                  it is high.
//   row_count    : rows completed since reset. It wraps, and it also counts
//                  dropped rows.
//   overflow_err : sticky. Set when a row total is dropped because the FIFO
//                  was full.
//   state_dbg    : current accumulator state
// ---------------------------------------------------------------------------
module dot8_accum
   import mvm_pkg::*;
#(
   parameter int IWIDTH     = DEF_IWIDTH,
   parameter int OWIDTH     = DEF_OWIDTH,
   parameter int CWIDTH     = DEF_CWIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int SLACK      = DEF_SLACK
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CWIDTH-1:0]    cfg_chunks,
   dot8_accum_if.slave          bus,
   output logic                 almost_full,
   output logic [ROW_CNT_W-1:0] row_count,
   output logic                 overflow_err,
   output accum_state_t         state_dbg
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   accum_state_t             state, state_d;
   logic signed [OWIDTH-1:0] acc, acc_d;
   logic [CWIDTH-1:0]        chunk_cnt, chunk_cnt_d;
   logic [CWIDTH-1:0]        n_r, n_r_d;
   logic [CWIDTH-1:0]        n_eff;
   logic signed [OWIDTH-1:0] idata_ext;
   logic signed [OWIDTH-1:0] acc_sum;
   logic                     row_done;
   logic [OWIDTH-1:0]        row_total;

   logic                     pop_req;
   logic [CNT_W-1:0]         fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;

   assign idata_ext = OWIDTH'($signed(bus.idata));
   assign n_eff     = (cfg_chunks == '0) ? CWIDTH'(1) : cfg_chunks;
   assign acc_sum   = acc + idata_ext;

   // Next-state logic. The row total is the fresh sum that includes this
   // chunk, so it reaches the FIFO on the same edge that samples the last
   // chunk.
   always_comb begin
      state_d     = state;
      acc_d       = acc;
      chunk_cnt_d = chunk_cnt;
      n_r_d       = n_r;
      row_done    = 1'b0;
      row_total   = '0;
      if (bus.ivalid) begin
         unique case (state)
            IDLE: begin
               n_r_d = n_eff;
               acc_d = idata_ext;
               if (n_eff == CWIDTH'(1)) begin
                  row_done  = 1'b1;
                  row_total = idata_ext;
               end else begin
                  chunk_cnt_d = CWIDTH'(1);
                  state_d     = ACCUM;
               end
            end
            ACCUM: begin
               acc_d = acc_sum;
               if ((chunk_cnt + CWIDTH'(1)) == n_r) begin
                  row_done    = 1'b1;
                  row_total   = acc_sum;
                  chunk_cnt_d = '0;
                  state_d     = IDLE;
               end else begin
                  chunk_cnt_d = chunk_cnt + CWIDTH'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         chunk_cnt <= '0;
         n_r       <= '0;
      end else begin
         state     <= state_d;
         acc       <= acc_d;
         chunk_cnt <= chunk_cnt_d;
         n_r       <= n_r_d;
      end
   end

   assign pop_req = bus.ovalid && bus.oready;

   sync_fifo #(
      .WIDTH (OWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (row_done),
      .wr_data (row_total),
      .pop     (pop_req),
      .rd_data (bus.odata),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.ovalid = !fifo_empty;

   // Depends only on the registered occupancy, so it has no combinational
   // path from ivalid or oready.
   assign almost_full = (CNT_W'(FIFO_DEPTH) - fifo_count) <= CNT_W'(SLACK);

   always_ff @(posedge clk) begin
      if (rst) begin
         row_count    <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (row_done) begin
            row_count <= row_count + 1'b1;
         end
         if (row_done && fifo_full && !pop_req) begin
            overflow_err <= 1'b1;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_dot8_accum.sv
module tb_dot8_accum;
   import mvm_pkg::*;

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 rst;
   logic [7:0]           cfg_chunks;
   logic                 almost_full;
   logic [15:0]          row_count;
   logic                 overflow_err;
   accum_state_t         state_dbg;

   always #5 clk = ~clk;

   dot8_accum_if #(.IWIDTH(32), .OWIDTH(32)) bus ();

   dot8_accum #(
      .IWIDTH     (32),
      .OWIDTH     (32),
      .CWIDTH     (8),
      .FIFO_DEPTH (8),
      .SLACK      (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_chunks   (cfg_chunks),
      .bus          (bus.slave),
      .almost_full  (almost_full),
      .row_count    (row_count),
      .overflow_err (overflow_err),
      .state_dbg    (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   // reference model of the row accumulation
   logic [31:0] m_acc;
   int          m_cnt;
   int          m_n;
   int          m_rows;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // output monitor: compare every word the DUT hands over
   always @(negedge clk) begin
      if (!rst && bus.ovalid && bus.oready) begin
         if (exp_q.size() == 0) begin
            check("pop_without_expect", 32'd1, 32'd0);
         end else begin
            check("odata_pop", bus.odata, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ivalid = 1'b0;
      tick(2);
      rst = 1'b0;
      m_cnt = 0;
      m_rows = 0;
      m_acc = '0;
      exp_q.delete();
   endtask

   // drive one chunk for one cycle; drop=1 means the row total is expected to be lost
   task automatic send_chunk(input int v, input bit drop = 1'b0);
      bus.ivalid = 1'b1;
      bus.idata  = v;
      if (m_cnt == 0) begin
         m_n   = (cfg_chunks == 8'd0) ? 1 : int'(cfg_chunks);
         m_acc = v;
      end else begin
         m_acc = m_acc + v;
      end
      m_cnt++;
      if (m_cnt == m_n) begin
         m_cnt = 0;
         m_rows++;
         if (!drop) exp_q.push_back(m_acc);
      end
      tick(1);
      bus.ivalid = 1'b0;
   endtask

   task automatic drain();
      bus.oready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         tick(1);
      end
      check("drain_left", exp_q.size(), 32'd0);
      check("drain_ovalid", {31'd0, bus.ovalid}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.ivalid = 1'b0;
      bus.idata  = '0;
      bus.oready = 1'b1;
      cfg_chunks = 8'd0;
      do_reset();

      // reset state
      check("rst_ovalid", {31'd0, bus.ovalid}, 32'd0);
      check("rst_odata", bus.odata, 32'd0);
      check("rst_af", {31'd0, almost_full}, 32'd0);
      check("rst_rows", {16'd0, row_count}, 32'd0);
      check("rst_ovf", {31'd0, overflow_err}, 32'd0);
      check("rst_state", {31'd0, state_dbg}, {31'd0, IDLE});

      // basic row
      cfg_chunks = 8'd4;
      send_chunk(10);
      check("basic_state", {31'd0, state_dbg}, {31'd0, ACCUM});
      check("basic_early", {31'd0, bus.ovalid}, 32'd0);
      send_chunk(-3);
      send_chunk(7);
      send_chunk(1);
      check("basic_ovalid", {31'd0, bus.ovalid}, 32'd1);
      check("basic_odata", bus.odata, 32'd15);
      check("basic_rows", {16'd0, row_count}, 32'(m_rows));
      tick(2);

      // gaps, then zero config
      cfg_chunks = 8'd3;
      send_chunk(5);
      tick(2);
      send_chunk(5);
      check("gap_early", {31'd0, bus.ovalid}, 32'd0);
      send_chunk(5);
      check("gap_odata", bus.odata, 32'd15);
      tick(2);
      cfg_chunks = 8'd0;
      send_chunk(-8);
      check("zero_cfg_odata", bus.odata, 32'hFFFF_FFF8);
      check("zero_cfg_state", {31'd0, state_dbg}, {31'd0, IDLE});
      tick(2);

      // two's-complement wrap
      cfg_chunks = 8'd2;
      send_chunk(32'h7FFF_FFFF);
      send_chunk(1);
      check("wrap_odata", bus.odata, 32'h8000_0000);
      check("wrap_ovf", {31'd0, overflow_err}, 32'd0);
      tick(2);

      // backpressure: fill, overflow, drain in order
      bus.oready = 1'b0;
      cfg_chunks = 8'd1;
      send_chunk(1);
      tick(1);
      check("bp_af_1", {31'd0, almost_full}, 32'd0);
      send_chunk(2);
      tick(1);
      check("bp_af_2", {31'd0, almost_full}, 32'd1);
      for (int v = 3; v <= 8; v++) send_chunk(v);
      check("bp_ovf_before", {31'd0, overflow_err}, 32'd0);
      send_chunk(9, 1'b1);
      tick(1);
      check("bp_ovf_after", {31'd0, overflow_err}, 32'd1);
      check("bp_rows", {16'd0, row_count}, 32'(m_rows));
      check("bp_head_stable", bus.odata, 32'd1);
      drain();

      // full with simultaneous pop
      do_reset();
      bus.oready = 1'b0;
      cfg_chunks = 8'd1;
      for (int v = 11; v <= 18; v++) send_chunk(v);
      tick(1);
      check("fp_af", {31'd0, almost_full}, 32'd1);
      check("fp_head", bus.odata, 32'd11);
      bus.oready = 1'b1;
      send_chunk(19);
      bus.oready = 1'b0;
      tick(1);
      check("fp_ovf", {31'd0, overflow_err}, 32'd0);
      check("fp_head2", bus.odata, 32'd12);
      check("fp_af2", {31'd0, almost_full}, 32'd1);
      drain();

      // reset mid-row
      cfg_chunks = 8'd4;
      send_chunk(100);
      send_chunk(200);
      do_reset();
      check("mr_state", {31'd0, state_dbg}, {31'd0, IDLE});
      check("mr_ovalid", {31'd0, bus.ovalid}, 32'd0);
      check("mr_rows", {16'd0, row_count}, 32'd0);
      check("mr_odata", bus.odata, 32'd0);
      for (int i = 0; i < 4; i++) send_chunk(1);
      check("mr_odata_new", bus.odata, 32'd4);
      check("mr_rows_new", {16'd0, row_count}, 32'd1);
      tick(3);
      check("sb_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1);
   end

endmodule
